// File: rtl/pipe_pkg.sv
// Flag-pipeline constants and helpers shared by flag_unit, branch_unit and control.
// Flags are ordered {N, Z, C, V}.
package pipe_pkg;

  localparam int FLAG_W = 4;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam logic [3:0] MASK_ALL   = 4'b1111;
  localparam logic [3:0] MASK_LOGIC = 4'b1110;
  localparam logic [3:0] MASK_NZ    = 4'b1100;

  typedef struct packed {
    logic              valid;
    logic [FLAG_W-1:0] data;
  } flag_pend_t;

  // Replace only the bits selected by mask; all other bits keep their old value.
  function automatic logic [FLAG_W-1:0] merge_flags(
    input logic [FLAG_W-1:0] old_flags,
    input logic [FLAG_W-1:0] upd_flags,
    input logic [FLAG_W-1:0] mask
  );
    return (old_flags & ~mask) | (upd_flags & mask);
  endfunction

endpackage

// File: rtl/flag_pend_stage.sv
// One in-flight flag write {valid, data}; holds its contents while the pipeline stalls.
module flag_pend_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              valid_i,
  input  logic [FLAG_W-1:0] data_i,
  output logic              valid_o,
  output logic [FLAG_W-1:0] data_o
);

  flag_pend_t pend_d;
  flag_pend_t pend_q;

  // Next-entry selection: keep the current entry on hold, otherwise take the upstream one.
  always_comb begin
    pend_d = pend_q;
    if (hold_i) begin
      pend_d = pend_q;
    end else begin
      pend_d.valid = valid_i;
      pend_d.data  = data_i;
    end
  end

  // Entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '{valid: 1'b0, data: {FLAG_W{1'b0}}};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign valid_o = pend_q.valid;
  assign data_o  = pend_q.data;

endmodule

// File: rtl/flag_unit.sv
// NZCV flag producer: captures EX flag writes, tracks them through MEM/WB, commits
// them architecturally, merges multiplier N/Z results and forwards the youngest value.
module flag_unit
  import pipe_pkg::*;
#(
  parameter int                 FLAG_W_P = FLAG_W,
  parameter logic [FLAG_W-1:0]  MUL_MASK = MASK_NZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              set_flags,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] alu_mask,
  input  logic              stall,
  input  logic              flush,
  input  logic              mul_start,
  input  logic              mul_done,
  input  logic [FLAG_W-1:0] mul_flags,
  output logic [FLAG_W-1:0] flags,
  output logic [FLAG_W-1:0] flags_arch,
  output logic              flag_hazard,
  output logic              mul_err
);

  logic              cap_s;
  logic [FLAG_W-1:0] fwd_flags_s;
  logic [FLAG_W-1:0] new_flags_s;

  logic              mem_valid_s;
  logic [FLAG_W-1:0] mem_data_s;
  logic              wb_valid_s;
  logic [FLAG_W-1:0] wb_data_s;

  logic [FLAG_W-1:0] arch_d;
  logic [FLAG_W-1:0] arch_q;
  logic              mul_busy_d;
  logic              mul_busy_q;
  logic              mul_err_d;
  logic              mul_err_q;

  logic              mul_commit_s;

  // Forwarded view: youngest valid in-flight write wins, else the committed flags.
  always_comb begin
    fwd_flags_s = arch_q;
    if (mem_valid_s) begin
      fwd_flags_s = mem_data_s;
    end else if (wb_valid_s) begin
      fwd_flags_s = wb_data_s;
    end else begin
      fwd_flags_s = arch_q;
    end
  end

  // Merging onto the forwarded view keeps the newest C/V for partially updating ops.
  assign cap_s       = ex_valid & set_flags & ~flush & ~stall;
  assign new_flags_s = merge_flags(fwd_flags_s, alu_flags, alu_mask);

  flag_pend_stage u_pend_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (stall),
    .valid_i (cap_s),
    .data_i  (new_flags_s),
    .valid_o (mem_valid_s),
    .data_o  (mem_data_s)
  );

  flag_pend_stage u_pend_wb (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (stall),
    .valid_i (mem_valid_s),
    .data_i  (mem_data_s),
    .valid_o (wb_valid_s),
    .data_o  (wb_data_s)
  );

  assign mul_commit_s = mul_done & mul_busy_q;

  // Architectural commit: WB write first (not while stalled), then multiply N/Z on top.
  always_comb begin
    arch_d = arch_q;
    if (!stall && wb_valid_s) begin
      arch_d = wb_data_s;
    end else begin
      arch_d = arch_q;
    end
    if (mul_commit_s) begin
      arch_d = merge_flags(arch_d, mul_flags, MUL_MASK);
    end else begin
      arch_d = arch_d;
    end
  end

  // Multiply tracking: a start in the completing cycle re-arms busy without an error.
  always_comb begin
    mul_busy_d = mul_busy_q;
    mul_err_d  = mul_err_q;
    if (mul_commit_s) begin
      mul_busy_d = mul_start;
    end else if (mul_start) begin
      if (mul_busy_q) begin
        mul_err_d = 1'b1;
      end else begin
        mul_busy_d = 1'b1;
      end
    end else begin
      mul_busy_d = mul_busy_q;
    end
  end

  // Architectural flags and multiply status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_q     <= {FLAG_W{1'b0}};
      mul_busy_q <= 1'b0;
      mul_err_q  <= 1'b0;
    end else begin
      arch_q     <= arch_d;
      mul_busy_q <= mul_busy_d;
      mul_err_q  <= mul_err_d;
    end
  end

  assign flags       = fwd_flags_s;
  assign flags_arch  = arch_q;
  assign flag_hazard = mul_busy_q;
  assign mul_err     = mul_err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed, table-driven check of flag_unit forwarding, commit, stall/flush and multiply.
module tb_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       ex_valid;
  logic       set_flags;
  logic [3:0] alu_flags;
  logic [3:0] alu_mask;
  logic       stall;
  logic       flush;
  logic       mul_start;
  logic       mul_done;
  logic [3:0] mul_flags;
  logic [3:0] flags;
  logic [3:0] flags_arch;
  logic       flag_hazard;
  logic       mul_err;

  int total;
  int bad;

  typedef struct {
    logic       ev;
    logic       sf;
    logic [3:0] af;
    logic [3:0] am;
    logic       st;
    logic       fl;
    logic       ms;
    logic       md;
    logic [3:0] mf;
    logic [3:0] e_flags;
    logic [3:0] e_arch;
    logic       e_haz;
    logic       e_err;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  flag_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .set_flags   (set_flags),
    .alu_flags   (alu_flags),
    .alu_mask    (alu_mask),
    .stall       (stall),
    .flush       (flush),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_flags   (mul_flags),
    .flags       (flags),
    .flags_arch  (flags_arch),
    .flag_hazard (flag_hazard),
    .mul_err     (mul_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ev, input logic sf, input logic [3:0] af,
                              input logic [3:0] am, input logic st, input logic fl,
                              input logic ms, input logic md, input logic [3:0] mf,
                              input logic [3:0] e_flags, input logic [3:0] e_arch,
                              input logic e_haz, input logic e_err);
    vec_t v;
    v.ev = ev; v.sf = sf; v.af = af; v.am = am; v.st = st; v.fl = fl;
    v.ms = ms; v.md = md; v.mf = mf;
    v.e_flags = e_flags; v.e_arch = e_arch; v.e_haz = e_haz; v.e_err = e_err;
    return v;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; set_flags = 1'b0; alu_flags = 4'b0000; alu_mask = 4'b0000;
    stall = 1'b0; flush = 1'b0; mul_start = 1'b0; mul_done = 1'b0; mul_flags = 4'b0000;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ef, input logic [3:0] ea,
                           input logic eh, input logic ee);
    check4({tag, ".flags"}, flags, ef);
    check4({tag, ".flags_arch"}, flags_arch, ea);
    check1({tag, ".flag_hazard"}, flag_hazard, eh);
    check1({tag, ".mul_err"}, mul_err, ee);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    rst_n = 1'b0;

    // columns: ev sf af am st fl ms md mf | flags arch haz err (after the edge)
    vecs[0]  = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0000,4'b0000,0,0);
    vecs[1]  = mk(1,1,4'b0100,4'b1111,0,0,0,0,4'b0000, 4'b0100,4'b0000,0,0);
    vecs[2]  = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0100,4'b0000,0,0);
    vecs[3]  = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0100,4'b0100,0,0);
    vecs[4]  = mk(1,1,4'b0011,4'b1111,0,0,0,0,4'b0000, 4'b0011,4'b0100,0,0);
    vecs[5]  = mk(1,1,4'b1000,4'b1110,0,0,0,0,4'b0000, 4'b1001,4'b0100,0,0);
    vecs[6]  = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b1001,4'b0011,0,0);
    vecs[7]  = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b1001,4'b1001,0,0);
    vecs[8]  = mk(1,1,4'b0100,4'b1111,0,0,0,0,4'b0000, 4'b0100,4'b1001,0,0);
    vecs[9]  = mk(1,1,4'b1000,4'b1111,0,0,0,0,4'b0000, 4'b1000,4'b1001,0,0);
    vecs[10] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b1000,4'b0100,0,0);
    vecs[11] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b1000,4'b1000,0,0);
    vecs[12] = mk(1,1,4'b0010,4'b1111,0,1,0,0,4'b0000, 4'b1000,4'b1000,0,0);
    vecs[13] = mk(1,1,4'b0001,4'b1111,0,0,0,0,4'b0000, 4'b0001,4'b1000,0,0);
    vecs[14] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0001,4'b1000,0,0);
    vecs[15] = mk(1,1,4'b1111,4'b1111,1,0,0,0,4'b0000, 4'b0001,4'b1000,0,0);
    vecs[16] = mk(1,1,4'b1111,4'b1111,1,1,0,0,4'b0000, 4'b0001,4'b1000,0,0);
    vecs[17] = mk(0,0,4'b0000,4'b0000,1,0,0,0,4'b0000, 4'b0001,4'b1000,0,0);
    vecs[18] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0001,4'b0001,0,0);
    vecs[19] = mk(0,0,4'b0000,4'b0000,0,0,1,0,4'b0000, 4'b0001,4'b0001,1,0);
    vecs[20] = mk(1,1,4'b0010,4'b1111,0,0,0,0,4'b0000, 4'b0010,4'b0001,1,0);
    vecs[21] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0010,4'b0001,1,0);
    vecs[22] = mk(0,0,4'b0000,4'b0000,0,0,1,1,4'b1000, 4'b1010,4'b1010,1,0);
    vecs[23] = mk(0,0,4'b0000,4'b0000,0,0,1,0,4'b0000, 4'b1010,4'b1010,1,1);
    vecs[24] = mk(1,1,4'b0001,4'b1111,0,0,0,0,4'b0000, 4'b0001,4'b1010,1,1);
    vecs[25] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0001,4'b1010,1,1);
    vecs[26] = mk(0,0,4'b0000,4'b0000,0,0,0,0,4'b0000, 4'b0001,4'b0001,1,1);
    vecs[27] = mk(0,0,4'b0000,4'b0000,0,0,0,1,4'b1111, 4'b1101,4'b1101,0,1);
    vecs[28] = mk(0,0,4'b0000,4'b0000,0,0,0,1,4'b0000, 4'b1101,4'b1101,0,1);
    vecs[29] = mk(0,0,4'b0000,4'b0000,0,0,1,0,4'b0000, 4'b1101,4'b1101,1,1);
    vecs[30] = mk(0,0,4'b0000,4'b0000,1,0,0,1,4'b0000, 4'b0001,4'b0001,0,1);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ex_valid  = vecs[i].ev;
      set_flags = vecs[i].sf;
      alu_flags = vecs[i].af;
      alu_mask  = vecs[i].am;
      stall     = vecs[i].st;
      flush     = vecs[i].fl;
      mul_start = vecs[i].ms;
      mul_done  = vecs[i].md;
      mul_flags = vecs[i].mf;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_flags, vecs[i].e_arch,
                vecs[i].e_haz, vecs[i].e_err);
    end

    // Mid-run async reset with a multiply busy and both pending stages valid.
    @(negedge clk);
    drive_idle();
    mul_start = 1'b1;
    ex_valid = 1'b1; set_flags = 1'b1; alu_flags = 4'b0110; alu_mask = 4'b1111;
    @(posedge clk);
    #1;
    @(negedge clk);
    drive_idle();
    ex_valid = 1'b1; set_flags = 1'b1; alu_flags = 4'b1010; alu_mask = 4'b1111;
    @(posedge clk);
    #1;
    check_all("pre_reset", 4'b1010, 4'b0001, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("post_reset_no_commit", 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
